// File: rtl/vliw_regfile.sv
// Multi-lane VLIW register file: combinational reads, falling-edge writes,
// and rising-edge write-conflict status tracking.
module vliw_regfile #(
    parameter int XLEN        = 32,
    parameter int NLANES      = 4,
    parameter bit E_SUPPORTED = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NLANES-1:0]            we3,
    input  logic [NLANES-1:0][4:0]       a1,
    input  logic [NLANES-1:0][4:0]       a2,
    input  logic [NLANES-1:0][4:0]       a3,
    input  logic [NLANES-1:0][XLEN-1:0]  wd3,
    output logic [NLANES-1:0][XLEN-1:0]  rd1,
    output logic [NLANES-1:0][XLEN-1:0]  rd2,
    input  logic                         ClearConflict,
    output logic                         WriteConflict,
    output logic [NLANES-1:0]            ConflictLane,
    output logic [7:0]                   ConflictCount
);

    // In the reduced (E) configuration the top address bit is simply not decoded.
    localparam int AW    = E_SUPPORTED ? 4 : 5;
    localparam int NREGS = 1 << AW;

    logic [XLEN-1:0]             regs_q [NREGS];
    logic [NLANES-1:0][AW-1:0]   wAddr;
    logic [NLANES-1:0][AW-1:0]   rAddr1;
    logic [NLANES-1:0][AW-1:0]   rAddr2;
    logic [NLANES-1:0]           laneValid;
    logic [NLANES-1:0]           dropped;
    logic [NREGS-1:0]            regWe;
    logic [XLEN-1:0]             regWd [NREGS];

    logic                        flag_q, flag_d;
    logic [NLANES-1:0]           lane_q, lane_d;
    logic [7:0]                  count_q, count_d;

    always_comb begin
        for (int i = 0; i < NLANES; i++) begin
            wAddr[i]     = a3[i][AW-1:0];
            rAddr1[i]    = a1[i][AW-1:0];
            rAddr2[i]    = a2[i][AW-1:0];
            laneValid[i] = we3[i] && (wAddr[i] != '0);
        end
    end

    // A lane loses if any higher-indexed valid lane targets the same register.
    always_comb begin
        for (int i = 0; i < NLANES; i++) begin
            dropped[i] = 1'b0;
            for (int j = i + 1; j < NLANES; j++) begin
                if (laneValid[i] && laneValid[j] && (wAddr[i] == wAddr[j])) begin
                    dropped[i] = 1'b1;
                end
            end
        end
    end

    // Ascending lane order lets the highest lane overwrite lower ones.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regWe[r] = 1'b0;
            regWd[r] = '0;
        end
        for (int i = 0; i < NLANES; i++) begin
            if (laneValid[i]) begin
                regWe[wAddr[i]] = 1'b1;
                regWd[wAddr[i]] = wd3[i];
            end
        end
    end

    // Falling-edge commit gives same-cycle write-to-read bypass.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (regWe[r]) begin
                    regs_q[r] <= regWd[r];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NLANES; i++) begin
            rd1[i] = (rAddr1[i] == '0) ? '0 : regs_q[rAddr1[i]];
            rd2[i] = (rAddr2[i] == '0) ? '0 : regs_q[rAddr2[i]];
        end
    end

    // A conflict in the same cycle as a clear wins and restarts the count at 1.
    always_comb begin
        flag_d  = flag_q;
        lane_d  = lane_q;
        count_d = count_q;
        if (|dropped) begin
            flag_d  = 1'b1;
            lane_d  = dropped;
            if (ClearConflict) begin
                count_d = 8'd1;
            end else if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
        end else if (ClearConflict) begin
            flag_d  = 1'b0;
            lane_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_q  <= 1'b0;
            lane_q  <= '0;
            count_q <= '0;
        end else begin
            flag_q  <= flag_d;
            lane_q  <= lane_d;
            count_q <= count_d;
        end
    end

    assign WriteConflict = flag_q;
    assign ConflictLane  = lane_q;
    assign ConflictCount = count_q;

endmodule

// File: tb/tb_vliw_regfile.sv
// Scoreboard bench for vliw_regfile: full-size and reduced (E) instances share stimulus.
module tb_vliw_regfile;

    localparam int XLEN = 32;
    localparam int NL   = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NL-1:0]            we3;
    logic [NL-1:0][4:0]       a1, a2, a3;
    logic [NL-1:0][XLEN-1:0]  wd3;
    logic                     ClearConflict;

    logic [NL-1:0][XLEN-1:0]  rd1, rd2;
    logic                     WriteConflict;
    logic [NL-1:0]            ConflictLane;
    logic [7:0]               ConflictCount;

    logic [NL-1:0][XLEN-1:0]  eRd1, eRd2;
    logic                     eWriteConflict;
    logic [NL-1:0]            eConflictLane;
    logic [7:0]               eConflictCount;

    typedef struct {
        string           tag;
        logic [XLEN-1:0] value;
    } exp_t;

    exp_t            expQ[$];
    exp_t            e;
    int              compared   = 0;
    int              mismatched = 0;
    logic [XLEN-1:0] model [32];

    vliw_regfile #(.XLEN(XLEN), .NLANES(NL), .E_SUPPORTED(1'b0)) dut (
        .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
        .rd1(rd1), .rd2(rd2), .ClearConflict(ClearConflict),
        .WriteConflict(WriteConflict), .ConflictLane(ConflictLane), .ConflictCount(ConflictCount)
    );

    vliw_regfile #(.XLEN(XLEN), .NLANES(NL), .E_SUPPORTED(1'b1)) dutE (
        .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
        .rd1(eRd1), .rd2(eRd2), .ClearConflict(ClearConflict),
        .WriteConflict(eWriteConflict), .ConflictLane(eConflictLane), .ConflictCount(eConflictCount)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clearInputs();
        we3 = '0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; ClearConflict = 1'b0;
    endtask

    task automatic setWrite(input int lane, input logic [4:0] addr, input logic [XLEN-1:0] data);
        we3[lane] = 1'b1;
        a3[lane]  = addr;
        wd3[lane] = data;
    endtask

    // Reference behaviour for the full-size file: ascending lanes, highest wins, x0 ignored.
    task automatic commitModel();
        for (int i = 0; i < NL; i++) begin
            if (we3[i] && a3[i] != 5'd0) model[a3[i]] = wd3[i];
        end
    endtask

    task automatic pushExp(input string tag, input logic [XLEN-1:0] v);
        exp_t x;
        x.tag   = tag;
        x.value = v;
        expQ.push_back(x);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clearInputs();
        for (int r = 0; r < 32; r++) model[r] = '0;
        a1[0] = 5'd3;
        #12;
        pushExp("reset_flag", '0);
        pushExp("reset_lane", '0);
        pushExp("reset_count", '0);
        pushExp("reset_rd", '0);
        e = expQ.pop_front(); compared++;
        if (XLEN'(WriteConflict) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, WriteConflict, e.value); end
        e = expQ.pop_front(); compared++;
        if (XLEN'(ConflictLane) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, ConflictLane, e.value); end
        e = expQ.pop_front(); compared++;
        if (XLEN'(ConflictCount) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, ConflictCount, e.value); end
        e = expQ.pop_front(); compared++;
        if (rd1[0] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd1[0], e.value); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_bypass();
        clearInputs();
        setWrite(0, 5'd5, 32'hDEADBEEF);
        a1[2] = 5'd5;
        #1;
        pushExp("bypass_before_fall", model[5]);
        e = expQ.pop_front(); compared++;
        if (rd1[2] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd1[2], e.value); end
        pushExp("bypass_after_fall", 32'hDEADBEEF);
        @(negedge clk); #1;
        commitModel();
        e = expQ.pop_front(); compared++;
        if (rd1[2] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd1[2], e.value); end
        @(posedge clk); #1;
        clearInputs();
        pushExp("bypass_no_conflict", '0);
        e = expQ.pop_front(); compared++;
        if (XLEN'(WriteConflict) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, WriteConflict, e.value); end
    endtask

    task automatic test_conflict();
        setWrite(0, 5'd7, 32'h11);
        setWrite(1, 5'd7, 32'h22);
        setWrite(3, 5'd7, 32'h33);
        a1[0] = 5'd7;
        pushExp("conflict_x7", 32'h33);
        @(negedge clk); #1;
        commitModel();
        e = expQ.pop_front(); compared++;
        if (rd1[0] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd1[0], e.value); end
        pushExp("conflict_flag", 32'd1);
        pushExp("conflict_lane", 32'b0011);
        pushExp("conflict_count", 32'd1);
        @(posedge clk); #1;
        e = expQ.pop_front(); compared++;
        if (XLEN'(WriteConflict) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, WriteConflict, e.value); end
        e = expQ.pop_front(); compared++;
        if (XLEN'(ConflictLane) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, ConflictLane, e.value); end
        e = expQ.pop_front(); compared++;
        if (XLEN'(ConflictCount) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, ConflictCount, e.value); end
        clearInputs();
        setWrite(2, 5'd9, 32'h99);
        a1[1] = 5'd9;
        pushExp("single_write_x9", 32'h99);
        @(negedge clk); #1;
        commitModel();
        e = expQ.pop_front(); compared++;
        if (rd1[1] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd1[1], e.value); end
        pushExp("hold_lane", 32'b0011);
        pushExp("hold_count", 32'd1);
        @(posedge clk); #1;
        e = expQ.pop_front(); compared++;
        if (XLEN'(ConflictLane) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, ConflictLane, e.value); end
        e = expQ.pop_front(); compared++;
        if (XLEN'(ConflictCount) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, ConflictCount, e.value); end
        clearInputs();
    endtask

    task automatic test_x0();
        ClearConflict = 1'b1;
        pushExp("clear_flag", '0);
        pushExp("clear_count", '0);
        @(posedge clk); #1;
        e = expQ.pop_front(); compared++;
        if (XLEN'(WriteConflict) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, WriteConflict, e.value); end
        e = expQ.pop_front(); compared++;
        if (XLEN'(ConflictCount) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, ConflictCount, e.value); end
        clearInputs();
        for (int i = 0; i < NL; i++) begin
            setWrite(i, 5'd0, 32'hFFFF);
            a2[i] = 5'd7;
            pushExp($sformatf("x0_rd1_lane%0d", i), '0);
            pushExp($sformatf("x7_rd2_lane%0d", i), model[7]);
        end
        @(negedge clk); #1;
        commitModel();
        for (int i = 0; i < NL; i++) begin
            e = expQ.pop_front(); compared++;
            if (rd1[i] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd1[i], e.value); end
            e = expQ.pop_front(); compared++;
            if (rd2[i] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd2[i], e.value); end
        end
        pushExp("x0_no_conflict", '0);
        @(posedge clk); #1;
        e = expQ.pop_front(); compared++;
        if (XLEN'(WriteConflict) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, WriteConflict, e.value); end
        clearInputs();
    endtask

    task automatic test_distinct();
        for (int i = 0; i < NL; i++) begin
            setWrite(i, 5'(i + 1), $urandom());
            a1[i] = 5'(i + 1);
            a2[i] = 5'(NL - i);
        end
        commitModel();
        for (int i = 0; i < NL; i++) begin
            pushExp($sformatf("distinct_rd1_lane%0d", i), model[i + 1]);
            pushExp($sformatf("distinct_rd2_lane%0d", i), model[NL - i]);
        end
        @(negedge clk); #1;
        for (int i = 0; i < NL; i++) begin
            e = expQ.pop_front(); compared++;
            if (rd1[i] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd1[i], e.value); end
            e = expQ.pop_front(); compared++;
            if (rd2[i] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd2[i], e.value); end
        end
        pushExp("distinct_no_conflict", '0);
        @(posedge clk); #1;
        e = expQ.pop_front(); compared++;
        if (XLEN'(WriteConflict) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, WriteConflict, e.value); end
        clearInputs();
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 300; c++) begin
            clearInputs();
            setWrite(0, 5'd8, 32'(c));
            setWrite(1, 5'd8, 32'(c + 1000));
            commitModel();
            @(posedge clk); #1;
        end
        pushExp("sat_count", 32'd255);
        pushExp("sat_lane", 32'b0001);
        e = expQ.pop_front(); compared++;
        if (XLEN'(ConflictCount) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, ConflictCount, e.value); end
        e = expQ.pop_front(); compared++;
        if (XLEN'(ConflictLane) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, ConflictLane, e.value); end
        clearInputs();
        ClearConflict = 1'b1;
        setWrite(2, 5'd8, 32'hA5A5);
        setWrite(3, 5'd8, 32'h5A5A);
        a1[3] = 5'd8;
        commitModel();
        pushExp("clear_vs_conflict_x8", 32'h5A5A);
        @(negedge clk); #1;
        e = expQ.pop_front(); compared++;
        if (rd1[3] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd1[3], e.value); end
        pushExp("clear_vs_conflict_count", 32'd1);
        pushExp("clear_vs_conflict_flag", 32'd1);
        pushExp("clear_vs_conflict_lane", 32'b0100);
        @(posedge clk); #1;
        e = expQ.pop_front(); compared++;
        if (XLEN'(ConflictCount) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, ConflictCount, e.value); end
        e = expQ.pop_front(); compared++;
        if (XLEN'(WriteConflict) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, WriteConflict, e.value); end
        e = expQ.pop_front(); compared++;
        if (XLEN'(ConflictLane) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, ConflictLane, e.value); end
        clearInputs();
    endtask

    task automatic test_esupported();
        setWrite(0, 5'd17, 32'hAB);
        setWrite(1, 5'd16, 32'h55);
        a1[0] = 5'd1;
        a1[1] = 5'd16;
        a1[2] = 5'd17;
        commitModel();
        pushExp("e_x1_alias", 32'hAB);
        pushExp("e_x16_zero", '0);
        pushExp("e_x17", 32'hAB);
        pushExp("full_x16", 32'h55);
        pushExp("full_x1", model[1]);
        @(negedge clk); #1;
        e = expQ.pop_front(); compared++;
        if (eRd1[0] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, eRd1[0], e.value); end
        e = expQ.pop_front(); compared++;
        if (eRd1[1] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, eRd1[1], e.value); end
        e = expQ.pop_front(); compared++;
        if (eRd1[2] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, eRd1[2], e.value); end
        e = expQ.pop_front(); compared++;
        if (rd1[1] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd1[1], e.value); end
        e = expQ.pop_front(); compared++;
        if (rd1[0] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd1[0], e.value); end
        @(posedge clk); #1;
        clearInputs();
    endtask

    task automatic test_reset_midcycle();
        for (int base = 1; base < 32; base += NL) begin
            clearInputs();
            for (int i = 0; i < NL; i++) begin
                if (base + i < 32) setWrite(i, 5'(base + i), 32'hC000_0000 | 32'((base + i) * 16 + 3));
            end
            commitModel();
            @(posedge clk); #1;
        end
        clearInputs();
        setWrite(0, 5'd3, 32'h1);
        setWrite(1, 5'd3, 32'h2);
        commitModel();
        @(posedge clk); #1;
        clearInputs();
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < NL; i++) begin
                a1[i] = 5'(g * 8 + i);
                a2[i] = 5'(g * 8 + 4 + i);
                pushExp($sformatf("pop_rd1_x%0d", g * 8 + i), model[g * 8 + i]);
                pushExp($sformatf("pop_rd2_x%0d", g * 8 + 4 + i), model[g * 8 + 4 + i]);
            end
            #1;
            for (int i = 0; i < NL; i++) begin
                e = expQ.pop_front(); compared++;
                if (rd1[i] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd1[i], e.value); end
                e = expQ.pop_front(); compared++;
                if (rd2[i] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd2[i], e.value); end
            end
        end
        @(posedge clk); #1;
        clearInputs();
        setWrite(0, 5'd5, 32'h77);
        for (int i = 0; i < NL; i++) begin
            a1[i] = 5'(5 + i);
            a2[i] = 5'(28 + i);
        end
        #1;
        reset = 1'b0;
        for (int r = 0; r < 32; r++) model[r] = '0;
        #1;
        for (int i = 0; i < NL; i++) begin
            pushExp($sformatf("rst_rd1_lane%0d", i), '0);
            pushExp($sformatf("rst_rd2_lane%0d", i), '0);
        end
        for (int i = 0; i < NL; i++) begin
            e = expQ.pop_front(); compared++;
            if (rd1[i] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd1[i], e.value); end
            e = expQ.pop_front(); compared++;
            if (rd2[i] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd2[i], e.value); end
        end
        pushExp("rst_flag", '0);
        pushExp("rst_count", '0);
        e = expQ.pop_front(); compared++;
        if (XLEN'(WriteConflict) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, WriteConflict, e.value); end
        e = expQ.pop_front(); compared++;
        if (XLEN'(ConflictCount) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, ConflictCount, e.value); end
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        pushExp("rst_aborted_write", '0);
        e = expQ.pop_front(); compared++;
        if (rd1[0] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd1[0], e.value); end
        commitModel();
        pushExp("first_write_after_rst", 32'h77);
        @(negedge clk); #1;
        e = expQ.pop_front(); compared++;
        if (rd1[0] !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %h want %h", e.tag, rd1[0], e.value); end
        @(posedge clk); #1;
        clearInputs();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_conflict();
        test_x0();
        test_distinct();
        test_saturation();
        test_esupported();
        test_reset_midcycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
